// File: rtl/intra_pkg.sv
// Shared constants and types for the intra-prediction neighbour fetch block.
package intra_pkg;

  localparam int MB_W   = 8;
  localparam int MB_L   = 8;
  localparam int IDX_W  = 5;

  localparam logic [7:0] DC_FILL = 8'd128;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

  // avail bit positions: {topright, left, top, corner}
  localparam int AV_CORNER = 0;
  localparam int AV_TOP    = 1;
  localparam int AV_LEFT   = 2;
  localparam int AV_TR     = 3;

  // Sample index groups: corner | top | topright | left
  localparam logic [IDX_W-1:0] IDX_CORNER = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_TR     = IDX_W'(1 + MB_W);
  localparam logic [IDX_W-1:0] IDX_LEFT   = IDX_W'(1 + 2*MB_W);
  localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(1 + 2*MB_W + MB_L);
  localparam int               NSMP       = 1 + 2*MB_W + MB_L;

endpackage

// File: rtl/intra_nbr_addr_gen.sv
// Combinational address and skip logic: raster address for a sample index
// and the next index whose group is available.
module intra_nbr_addr_gen
  import intra_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int ADDR_W = 20
) (
  input  logic [15:0]       row_i,
  input  logic [15:0]       col_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [3:0]        avail_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [IDX_W-1:0]  first_o,
  output logic [IDX_W-1:0]  next_o
);

  // Smallest available index >= from; IDX_END when none remain.
  function automatic logic [IDX_W-1:0] skip(input logic [3:0] av,
                                            input logic [IDX_W-1:0] from);
    logic [IDX_W-1:0] f;
    f = from;
    if (f < IDX_TOP && !av[AV_CORNER]) f = IDX_TOP;
    if (f >= IDX_TOP && f < IDX_TR && !av[AV_TOP]) f = IDX_TR;
    if (f >= IDX_TR && f < IDX_LEFT && !av[AV_TR]) f = IDX_LEFT;
    if (f >= IDX_LEFT && f < IDX_END && !av[AV_LEFT]) f = IDX_END;
    return f;
  endfunction

  logic [31:0] y, x;

  // Corner, top and topright are one contiguous run on row-1 starting at col-1.
  always_comb begin
    if (idx_i < IDX_LEFT) begin
      y = 32'(row_i) - 32'd1;
      x = 32'(col_i) + 32'(idx_i) - 32'd1;
    end else begin
      y = 32'(row_i) + 32'(idx_i - IDX_LEFT);
      x = 32'(col_i) - 32'd1;
    end
  end

  assign addr_o  = ADDR_W'(y * 32'(WIDTH) + x);
  assign first_o = skip(avail_i, IDX_CORNER);
  assign next_o  = skip(avail_i, idx_i + IDX_W'(1));

endmodule

// File: rtl/intra_neighbour_fetch.sv
// Fetches the 25 reconstructed neighbour samples of a macroblock from the
// raster frame buffer and presents them, with availability, to intra prediction.
module intra_neighbour_fetch
  import intra_pkg::*;
#(
  parameter int WIDTH     = 1280,
  parameter int LENGTH    = 720,
  parameter int MB_SIZE_L = MB_L,
  parameter int MB_SIZE_W = MB_W,
  parameter int ADDR_W    = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            mbnumber,
  output logic                   busy,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [7:0]             rd_data,
  output logic [7:0]             corner_px,
  output logic [8*MB_SIZE_W-1:0] top_px,
  output logic [8*MB_SIZE_W-1:0] topright_px,
  output logic [8*MB_SIZE_L-1:0] left_px,
  output logic [3:0]             avail,
  output logic                   done
);

  if (WIDTH * LENGTH > (1 << ADDR_W)) begin : g_frame_too_big
    $error("frame does not fit in ADDR_W address bits");
  end

  state_e                  state_q, state_d;
  logic [15:0]             row_q, col_q;
  logic [3:0]              avail_q, avail_new, avail_sel;
  logic [IDX_W-1:0]        idx_q, idx_d, first_idx, next_idx, cap_idx_q;
  logic                    cap_vld_q, rd_en_c;
  logic [ADDR_W-1:0]       addr_c;
  logic [NSMP-1:0][7:0]    smp_q;
  logic                    top_ok, left_ok, tr_ok;

  assign top_ok    = |mbnumber[31:16];
  assign left_ok   = |mbnumber[15:0];
  assign tr_ok     = top_ok && (32'(mbnumber[15:0]) + 32'(2*MB_SIZE_W) <= 32'(WIDTH));
  assign avail_new = {tr_ok, left_ok, top_ok, top_ok & left_ok};

  // In IDLE the first-index lookup must see the incoming availability.
  assign avail_sel = (state_q == IDLE) ? avail_new : avail_q;

  intra_nbr_addr_gen #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_addr (
    .row_i   (row_q),
    .col_i   (col_q),
    .idx_i   (idx_q),
    .avail_i (avail_sel),
    .addr_o  (addr_c),
    .first_o (first_idx),
    .next_o  (next_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rd_en_c = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        idx_d   = first_idx;
        state_d = (first_idx == IDX_END) ? DRAIN : FETCH;
      end
      FETCH: begin
        rd_en_c = 1'b1;
        idx_d   = next_idx;
        if (next_idx == IDX_END) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      avail_q   <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      smp_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cap_vld_q <= rd_en_c;
      cap_idx_q <= idx_q;
      if (state_q == IDLE && start) begin
        row_q   <= mbnumber[31:16];
        col_q   <= mbnumber[15:0];
        avail_q <= avail_new;
        for (int i = 0; i < NSMP; i++) smp_q[i] <= DC_FILL;
      end else if (cap_vld_q) begin
        smp_q[cap_idx_q] <= rd_data;
      end
    end
  end

  assign rd_en       = rd_en_c;
  assign rd_addr     = rd_en_c ? addr_c : '0;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign avail       = avail_q;
  assign corner_px   = smp_q[IDX_CORNER];
  assign top_px      = smp_q[IDX_TR-1:IDX_TOP];
  assign topright_px = smp_q[IDX_LEFT-1:IDX_TR];
  assign left_px     = smp_q[IDX_END-1:IDX_LEFT];

endmodule

// File: tb/tb_intra_neighbour_fetch.sv
// Directed bench: frame-buffer model returns address[7:0]; checks addresses,
// latency, availability and every output lane.
module tb_intra_neighbour_fetch;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] mbnumber;
  logic        busy, rd_en, done;
  logic [19:0] rd_addr;
  logic [7:0]  rd_data = 8'h00;
  logic [7:0]  corner_px;
  logic [63:0] top_px, topright_px, left_px;
  logic [3:0]  avail;

  intra_neighbour_fetch dut (
    .clk(clk), .reset(reset), .start(start), .mbnumber(mbnumber),
    .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .corner_px(corner_px), .top_px(top_px), .topright_px(topright_px),
    .left_px(left_px), .avail(avail), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= rd_addr[7:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int t0 = 0, nrd, first_rd, last_rd, done_cyc, ndone, nbusy;
  bit mon_en = 1'b0;
  int aq[$];

  always @(negedge clk) begin
    int k;
    if (mon_en) begin
      k = cyc - t0;
      if (rd_en) begin
        aq.push_back(int'(rd_addr));
        if (nrd == 0) first_rd = k;
        last_rd = k;
        nrd++;
      end
      if (done) begin ndone++; done_cyc = k; end
      if (busy) nbusy++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    aq.delete();
    nrd = 0; first_rd = -1; last_rd = -1; done_cyc = -1; ndone = 0; nbusy = 0;
  endtask

  // Start accepted at the edge ending cycle 0; rp1/rp2 re-pulse start, rst_at drops reset.
  task automatic do_mb(input int row, input int col, input int rp1, input int rp2, input int rst_at);
    @(negedge clk);
    clear_mon();
    mbnumber = {row[15:0], col[15:0]};
    start = 1'b1;
    t0 = cyc;
    mon_en = 1'b1;
    for (int g = 0; g < 200; g++) begin
      int k;
      @(negedge clk);
      k = cyc - t0;
      start = (k == rp1) || (k == rp2);
      if (k == rst_at) begin reset = 1'b0; break; end
      if (ndone > 0 && k >= done_cyc + 3) break;
    end
    start = 1'b0;
    mon_en = 1'b0;
  endtask

  task automatic verify(input string tag, input int row, input int col, input int n,
                        input logic [3:0] eav);
    bit t, l, c, tr;
    int eq[$];
    logic [63:0] etop, etr, eleft;
    logic [7:0]  ecorner;
    t = row > 0; l = col > 0; c = t && l; tr = t && (col + 16 <= 1280);
    if (c) eq.push_back((row-1)*1280 + col - 1);
    if (t)  for (int k = 0; k < 8; k++) eq.push_back((row-1)*1280 + col + k);
    if (tr) for (int k = 0; k < 8; k++) eq.push_back((row-1)*1280 + col + 8 + k);
    if (l)  for (int k = 0; k < 8; k++) eq.push_back((row+k)*1280 + col - 1);
    ecorner = c ? 8'((row-1)*1280 + col - 1) : 8'd128;
    for (int k = 0; k < 8; k++) begin
      etop[8*k +: 8]  = t  ? 8'((row-1)*1280 + col + k)     : 8'd128;
      etr[8*k +: 8]   = tr ? 8'((row-1)*1280 + col + 8 + k) : 8'd128;
      eleft[8*k +: 8] = l  ? 8'((row+k)*1280 + col - 1)     : 8'd128;
    end
    chk({tag, " avail"},    64'(avail), 64'(eav));
    chk({tag, " nreads"},   64'(nrd), 64'(n));
    chk({tag, " first_rd"}, 64'(first_rd), (n > 0) ? 64'(1) : 64'(-1));
    chk({tag, " last_rd"},  64'(last_rd), (n > 0) ? 64'(n) : 64'(-1));
    chk({tag, " done_cyc"}, 64'(done_cyc), 64'(n + 2));
    chk({tag, " ndone"},    64'(ndone), 64'(1));
    chk({tag, " nbusy"},    64'(nbusy), 64'(n + 2));
    for (int i = 0; i < eq.size() && i < aq.size(); i++)
      chk($sformatf("%s addr%0d", tag, i), 64'(aq[i]), 64'(eq[i]));
    chk({tag, " corner"},   64'(corner_px), 64'(ecorner));
    chk({tag, " top"},      top_px, etop);
    chk({tag, " topright"}, topright_px, etr);
    chk({tag, " left"},     left_px, eleft);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mbnumber = '0;
    clear_mon();
    repeat (2) @(negedge clk);
    chk("rst busy",  64'(busy), 64'(0));
    chk("rst rd_en", 64'(rd_en), 64'(0));
    chk("rst done",  64'(done), 64'(0));
    chk("rst addr",  64'(rd_addr), 64'(0));
    chk("rst avail", 64'(avail), 64'(0));
    chk("rst top",   top_px | topright_px | left_px | 64'(corner_px), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    do_mb(0, 0, -1, -1, -1);
    verify("mb0_0", 0, 0, 0, 4'b0000);

    do_mb(8, 8, -1, -1, -1);
    verify("mb8_8", 8, 8, 25, 4'b1111);
    chk("mb8_8 a0",  64'(aq[0]), 64'(8967));
    chk("mb8_8 a9",  64'(aq[9]), 64'(8976));
    chk("mb8_8 a17", 64'(aq[17]), 64'(10247));
    chk("mb8_8 a24", 64'(aq[24]), 64'(19207));

    do_mb(16, 1272, -1, -1, -1);
    verify("mb16_1272", 16, 1272, 17, 4'b0111);
    chk("mb16_1272 a0",  64'(aq[0]), 64'(20471));
    chk("mb16_1272 a9",  64'(aq[9]), 64'(21751));
    chk("mb16_1272 a16", 64'(aq[16]), 64'(30711));
    chk("mb16_1272 trfill", topright_px, {8{8'd128}});

    do_mb(0, 64, -1, -1, -1);
    verify("mb0_64", 0, 64, 8, 4'b0100);
    chk("mb0_64 a0", 64'(aq[0]), 64'(63));
    chk("mb0_64 a7", 64'(aq[7]), 64'(9023));
    chk("mb0_64 topfill", top_px, {8{8'd128}});

    // start during fetch and coincident with done must be ignored
    do_mb(8, 8, 5, 27, -1);
    verify("repulse", 8, 8, 25, 4'b1111);
    chk("repulse idle", 64'(busy), 64'(0));

    do_mb(8, 8, -1, -1, 10);
    #1;
    chk("midrst busy",  64'(busy), 64'(0));
    chk("midrst rd_en", 64'(rd_en), 64'(0));
    chk("midrst addr",  64'(rd_addr), 64'(0));
    chk("midrst avail", 64'(avail), 64'(0));
    chk("midrst outs",  top_px | topright_px | left_px | 64'(corner_px), 64'(0));
    clear_mon();
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("midrst nodone", 64'(ndone), 64'(0));
    chk("midrst noread", 64'(nrd), 64'(0));

    do_mb(8, 8, -1, -1, -1);
    verify("after_rst", 8, 8, 25, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
